// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button / switch input conditioner.
//   db_state_t              : per-channel debounce FSM state
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles needed to accept a change (10 ms at 6 ns)
//   CLK_PERIOD_NS           : system clock period the default above is derived from
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'b00,
        S_WAIT_HIGH = 2'b01,
        S_HIGH      = 2'b10,
        S_WAIT_LOW  = 2'b11
    } db_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1666667;
    localparam int unsigned CLK_PERIOD_NS           = 6;

    // Debounced level implied by a state: high while accepted-high or qualifying a release.
    function automatic logic state_level(input db_state_t st);
        return (st == S_HIGH) || (st == S_WAIT_LOW);
    endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Pin-side bundle of the button conditioner.
//   btn_in      : raw, asynchronous, active-high pin levels
//   btn_level   : debounced level per channel
//   btn_press   : one-cycle pulse on an accepted 0->1
//   btn_release : one-cycle pulse on an accepted 1->0
// master = the side driving the pins and consuming events; slave = the debouncer.
interface btn_debounce_if #(
    parameter int unsigned NB = 8
) ();

    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/debounce_channel.sv
// One debounce channel: SYNC_STAGES-deep synchronizer, qualification counter and
// four-state FSM. All outputs are registered.
//   clk, nrst   : system clock, asynchronous active-low reset
//   btn_in      : raw pin level (asynchronous)
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse in the first cycle btn_level reads 1
//   btn_release : one-cycle pulse in the first cycle btn_level reads 0
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, press_q, release_q;
    logic                   press_d, release_d;

    // Plain shift chain: nothing may sit between the metastability stages.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any reversal of s during a wait abandons the qualification; the count restarts
    // from one on the next candidate edge, so it never exceeds CNT_MAX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d   = S_HIGH;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = S_LOW;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is registered from the next state so it flips on the same edge as the pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= state_level(state_d);
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// Input-side conditioner for the board push-buttons and switches: NB independent
// channels, each synchronised, debounced and turned into level + press/release pulses.
//   clk  : system clock (same domain as the core logic)
//   nrst : asynchronous active-low reset
//   bus  : btn_debounce_if slave view (btn_in in; btn_level/btn_press/btn_release out)
module btn_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned NB              = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic           clk,
    input  logic           nrst,
    btn_debounce_if.slave  bus
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_debounce: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] release_p;

    for (genvar i = 0; i < NB; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .nrst        (nrst),
            .btn_in      (bus.btn_in[i]),
            .btn_level   (level[i]),
            .btn_press   (press[i]),
            .btn_release (release_p[i])
        );
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = release_p;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// From a settled state, a held input change is accepted on the 6th clock edge:
// 2 synchronizer edges, 1 edge entering the wait state, 3 more counting to 3.
module tb_btn_debounce;

    localparam int unsigned NB          = 8;
    localparam int          PULSE_EDGE  = 6;

    typedef struct {
        logic [7:0] stim;
        logic [7:0] lvl;
        logic [7:0] prs;
        logic [7:0] rel;
    } vec_t;

    logic clk;
    logic nrst;
    int   checks;
    int   failures;
    vec_t vecs[$];

    btn_debounce_if #(.NB(NB)) bus ();

    btn_debounce #(
        .NB              (NB),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %02h expected %02h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [7:0] lvl,
                             input logic [7:0] prs, input logic [7:0] rel);
        check({tag, ".level"}, idx, bus.btn_level, lvl);
        check({tag, ".press"}, idx, bus.btn_press, prs);
        check({tag, ".release"}, idx, bus.btn_release, rel);
    endtask

    function automatic void add(input logic [7:0] stim, input logic [7:0] lvl,
                                input logic [7:0] prs, input logic [7:0] rel);
        vec_t v;
        v.stim = stim;
        v.lvl  = lvl;
        v.prs  = prs;
        v.rel  = rel;
        vecs.push_back(v);
    endfunction

    // Hold one input value for n edges starting from a settled state.
    function automatic void add_hold(input logic [7:0] stim, input int n,
                                     input logic [7:0] lvl_old, input logic [7:0] lvl_new,
                                     input logic [7:0] prs, input logic [7:0] rel);
        for (int e = 1; e <= n; e++) begin
            if (e < PULSE_EDGE)       add(stim, lvl_old, 8'h00, 8'h00);
            else if (e == PULSE_EDGE) add(stim, lvl_new, prs, rel);
            else                      add(stim, lvl_new, 8'h00, 8'h00);
        end
    endfunction

    initial begin
        checks   = 0;
        failures = 0;

        // Clean press and release on ch0.
        add_hold(8'h01, 8, 8'h00, 8'h01, 8'h01, 8'h00);
        add_hold(8'h00, 8, 8'h01, 8'h00, 8'h00, 8'h01);
        // Bounce on ch3: one-cycle toggles never survive a full qualification.
        add(8'h08, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h00, 8'h00);
        add(8'h08, 8'h00, 8'h00, 8'h00);
        add(8'h00, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) add(8'h00, 8'h00, 8'h00, 8'h00);
        // Then a steady press and release on ch3.
        add_hold(8'h08, 8, 8'h00, 8'h08, 8'h08, 8'h00);
        add_hold(8'h00, 8, 8'h08, 8'h00, 8'h00, 8'h08);
        // Several channels in one step.
        add_hold(8'hA5, 8, 8'h00, 8'hA5, 8'hA5, 8'h00);

        bus.btn_in = 8'h00;
        nrst       = 1'b1;
        #1 nrst    = 1'b0;
        #2 check_all("reset", 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check_all("reset_held", 0, 8'h00, 8'h00, 8'h00);
        nrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.btn_in = vecs[i].stim;
            @(posedge clk);
            @(negedge clk);
            check_all("vec", i, vecs[i].lvl, vecs[i].prs, vecs[i].rel);
        end

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        #2 nrst    = 1'b0;
        bus.btn_in = 8'hFF;
        #1 check_all("async_reset", 0, 8'h00, 8'h00, 8'h00);

        // All buttons held through reset: one press once reset lifts.
        @(negedge clk);
        nrst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("held_reset", e, (e >= PULSE_EDGE) ? 8'hFF : 8'h00,
                      (e == PULSE_EDGE) ? 8'hFF : 8'h00, 8'h00);
        end

        // Reset in the middle of a ch0 qualification abandons it.
        nrst       = 1'b0;
        bus.btn_in = 8'h00;
        @(negedge clk);
        nrst       = 1'b1;
        bus.btn_in = 8'h01;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("pre_wait", e, 8'h00, 8'h00, 8'h00);
        end
        #1 nrst = 1'b0;
        #1 nrst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            check_all("requalify", e, (e >= PULSE_EDGE) ? 8'h01 : 8'h00,
                      (e == PULSE_EDGE) ? 8'h01 : 8'h00, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
